// File: rtl/fdc_host_if.sv
// Z80-side host interface of a floppy controller: MSR/data ports, command buffer, result buffer.
// Define FDC_MOTOR_REG_EN to build the motor latch decoded at 0x1FFD.
module fdc_host_if #(
  parameter int unsigned EXEC_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        oe,
  output logic        cmd_go,
  input  logic [3:0]  bk_addr,
  output logic [7:0]  bk_cmd,
  input  logic        res_we,
  input  logic [7:0]  res_data,
  input  logic        res_done,
  output logic        motor_on
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_EXEC, S_RESULT} state_t;

  localparam int unsigned TW       = (EXEC_TIMEOUT < 2) ? 1 : $clog2(EXEC_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(EXEC_TIMEOUT - 1);

  // Returns the total command length in bytes, 0 for an unknown opcode.
  function automatic logic [3:0] cmd_length(input logic [4:0] op);
    case (op)
      5'h02, 5'h05, 5'h06, 5'h09, 5'h0C, 5'h11, 5'h19, 5'h1D: cmd_length = 4'd9;
      5'h0D:                      cmd_length = 4'd6;
      5'h03, 5'h0F:               cmd_length = 4'd3;
      5'h04, 5'h07, 5'h0A:        cmd_length = 4'd2;
      5'h08:                      cmd_length = 4'd1;
      default:                    cmd_length = 4'd0;
    endcase
  endfunction

  state_t        state;
  logic [3:0]    cmd_idx, cmd_len;
  logic [2:0]    res_cnt, rd_idx;
  logic [TW-1:0] tmo_cnt;
  logic          data_rd_q, data_wr_q;
  logic [7:0]    cmd_buf [0:8];
  logic [7:0]    res_buf [0:6];

  logic       msr_sel, data_sel, msr_rd, data_rd, data_wr;
  logic       data_rd_ev, data_wr_ev;
  logic [3:0] op_len;
  logic       res_push, tmo_hit;
  logic [2:0] res_cnt_nxt;
  logic [7:0] msr_val;

  assign msr_sel    = !iorq_n && (a[15:12] == 4'h2) && !a[1];
  assign data_sel   = !iorq_n && (a[15:12] == 4'h3) && !a[1];
  assign msr_rd     = msr_sel && !rd_n && wr_n;
  assign data_rd    = data_sel && !rd_n && wr_n;
  assign data_wr    = data_sel && !wr_n;
  assign data_rd_ev = data_rd && !data_rd_q;
  assign data_wr_ev = data_wr && !data_wr_q;

  assign op_len      = cmd_length(din[4:0]);
  assign res_push    = res_we && (res_cnt != 3'd7);
  assign res_cnt_nxt = res_cnt + {2'b00, res_push};
  assign tmo_hit     = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see pre-edge values regardless of order.
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_idx   <= '0;
      cmd_len   <= '0;
      res_cnt   <= '0;
      rd_idx    <= '0;
      tmo_cnt   <= '0;
      cmd_go    <= 1'b0;
      data_rd_q <= 1'b0;
      data_wr_q <= 1'b0;
    end else begin
      data_rd_q <= data_rd;
      data_wr_q <= data_wr;
      cmd_go    <= 1'b0;
      case (state)
        S_IDLE: if (data_wr_ev) begin
          cmd_len <= op_len;
          cmd_idx <= 4'd1;
          if (op_len == 4'd0) begin
            state   <= S_RESULT;
            res_cnt <= 3'd1;
            rd_idx  <= '0;
          end else if (op_len == 4'd1) begin
            state   <= S_EXEC;
            cmd_go  <= 1'b1;
            tmo_cnt <= '0;
            res_cnt <= '0;
          end else begin
            state <= S_CMD;
          end
        end
        S_CMD: if (data_wr_ev) begin
          cmd_idx <= cmd_idx + 4'd1;
          if (cmd_idx == cmd_len - 4'd1) begin
            state   <= S_EXEC;
            cmd_go  <= 1'b1;
            tmo_cnt <= '0;
            res_cnt <= '0;
          end
        end
        S_EXEC: begin
          // res_done beats the timeout when both land on the same edge.
          if (res_done) begin
            res_cnt <= res_cnt_nxt;
            rd_idx  <= '0;
            state   <= (res_cnt_nxt != 3'd0) ? S_RESULT : S_IDLE;
          end else if (tmo_hit) begin
            res_cnt <= 3'd1;
            rd_idx  <= '0;
            state   <= S_RESULT;
          end else begin
            res_cnt <= res_cnt_nxt;
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESULT: if (data_rd_ev) begin
          if (rd_idx == res_cnt - 3'd1) begin
            state  <= S_IDLE;
            rd_idx <= '0;
          end else begin
            rd_idx <= rd_idx + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic       cmd_we, res_wr;
  logic [3:0] cmd_wa;
  logic [2:0] res_wa;
  logic [7:0] res_wd;

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
    cmd_we = data_wr_ev && ((state == S_IDLE) || (state == S_CMD));
    cmd_wa = (state == S_IDLE) ? 4'd0 : cmd_idx;
    res_wr = 1'b0;
    res_wa = res_cnt;
    res_wd = res_data;
    if ((state == S_IDLE) && data_wr_ev && (op_len == 4'd0)) begin
      res_wr = 1'b1;
      res_wa = 3'd0;
      res_wd = 8'h80;
    end else if (state == S_EXEC) begin
      if (!res_done && tmo_hit) begin
        res_wr = 1'b1;
        res_wa = 3'd0;
        res_wd = 8'h40;
      end else begin
        res_wr = res_push;
      end
    end
  end

  // NOTE: buffers carry no reset; their contents are only read behind valid indices/counts.
  always_ff @(posedge clk) begin
    if (cmd_we) cmd_buf[cmd_wa] <= din;
    if (res_wr) res_buf[res_wa] <= res_wd;
  end

  assign bk_cmd = (bk_addr > 4'd8) ? 8'hFF : cmd_buf[bk_addr];

  always_comb begin
    case (state)
      S_CMD:    msr_val = 8'h90;
      S_EXEC:   msr_val = 8'h30;
      S_RESULT: msr_val = 8'hD0;
      default:  msr_val = 8'h80;
    endcase
    if (!rst_n) msr_val = 8'h80;
  end

  always_comb begin
    dout = 8'hFF;
    if (msr_rd)                              dout = msr_val;
    else if (data_rd && (state == S_RESULT)) dout = res_buf[rd_idx];
  end

  assign oe = msr_rd || data_rd;

`ifdef FDC_MOTOR_REG_EN
  logic mot_wr, mot_wr_q;
  assign mot_wr = !iorq_n && (a[15:12] == 4'h1) && !a[1] && !wr_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      motor_on <= 1'b0;
      mot_wr_q <= 1'b0;
    end else begin
      mot_wr_q <= mot_wr;
      if (mot_wr && !mot_wr_q) motor_on <= din[3];
    end
  end
`else
  assign motor_on = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = ^{a[11:2], a[0]};

endmodule
